accu_outbuffer_drain: RTL
=========================

Name: accu_outbuffer_drain

Overview:
Read-side controller for the accumulation output buffer. After a layer finishes accumulating, it sweeps a contiguous address range of the bank array. It drives the shared read address and read enable, and captures the full row-parallel read word (one buffer_width slice per PE row). It streams each word out over a valid/ready interface toward the writeback/DMA path, with a 2-entry skid FIFO so backpressure never loses data.

Parameters:
nb_pe_row, 8, number of PE rows (one buffer bank per row)
buffer_width, 16, bits per bank word
buffer_depth, 8192, words per bank
buffer_addr_width, clogb2(buffer_depth)=13, bank address width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; launches a drain, sampled only in IDLE
base_addr  in  buffer_addr_width  first address, sampled with start
num_words  in  buffer_addr_width+1  words to drain (0..buffer_depth), sampled with start
rAddr  out  buffer_addr_width  bank read address
rEn  out  1  bank read enable
buffer_out_all_rows  in  nb_pe_row*buffer_width  bank read data; valid the cycle after rEn
out_data  out  nb_pe_row*buffer_width  streamed word; row i at bits [(i+1)*buffer_width-1 -: buffer_width]
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts when out_valid & out_ready
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at drain completion

Behaviour:
- Reset (async, rst_n=0): state IDLE; rEn=0, rAddr=0, out_valid=0, out_data=0, busy=0, done=0; FIFO emptied, in-flight flag and counters cleared. Reset mid-drain aborts the drain; no done pulse.
- States: IDLE -> READ on start; READ -> DRAIN when last read issued; DRAIN -> DONE when FIFO empty, nothing in flight and last word handshaken; DONE -> IDLE unconditionally after 1 cycle, with done=1 during DONE. start with num_words=0: IDLE -> DONE directly, with no rEn.
- start while busy is ignored. base_addr and num_words are registered at start; later changes have no effect.
- Read issue in READ: rEn=1 in a cycle only if remaining>0 and (fifo_cnt + inflight - pop) < 2. Here pop = out_valid & out_ready in the same cycle, and inflight = rEn of the previous cycle. Each issue advances rAddr by 1 and decrements remaining. rEn=0 in every other state.
- Address wrap: rAddr = (base_addr + k) mod buffer_depth. 8191 is followed by 0. num_words=buffer_depth reads every address exactly once.
- Read latency: 1 cycle. buffer_out_all_rows is written into the FIFO at the clock edge ending the cycle after rEn.
- FIFO: 2 entries, in order. out_valid=1 iff fifo_cnt>0, and out_data = head entry, registered. Push and pop in the same cycle are legal; fifo_cnt is unchanged. The credit rule guarantees no overflow. Push to a full FIFO is an assertion failure.
- Holding: while out_valid=1 and out_ready=0, out_data is stable. out_valid never drops without a handshake.
- Throughput: with out_ready held 1, one word per cycle. start sampled at cycle 0, so first rEn is at cycle 1 and first out_valid at cycle 3. For N words, the last handshake is at cycle N+2 and done is at cycle N+3.
- Data passes unmodified; no arithmetic on the payload. Counter widths: remaining and handshake counters are buffer_addr_width+1 bits.

Test Plan:
1. base_addr=0, num_words=4, out_ready=1, bank word at addr a = {nb_pe_row{a[15:0]}} -> rAddr 0,1,2,3 with rEn in cycles 1-4; out_valid in cycles 3-6 carrying words 0..3; done=1 in cycle 7 only; busy in cycles 1-7.
2. Wrap: base_addr=8190, num_words=4 -> rAddr sequence 8190,8191,0,1; out_data in the same order.
3. Backpressure: num_words=6, out_ready toggles 1,0,0,1,0,1,... -> all 6 words delivered exactly once, in order; out_data stable while stalled; rEn never high when fifo_cnt+inflight-pop=2; no FIFO overflow.
4. num_words=0 -> no rEn, no out_valid, done pulse the cycle after start. num_words=8192 from base 100 -> each address read once, ending at 99.
5. start pulsed again at cycle 3 of an active drain of 5 words -> ignored; exactly 5 words and a single done.
6. rst_n asserted mid-drain with 2 words in the FIFO -> all outputs go to 0 immediately; no done. A fresh start after release drains correctly from its new base_addr.

Source files
------------

// File: rtl/accu_outbuffer_drain_if.sv
// Bank read port and output stream of the accumulation output buffer drain.
// master = drain controller, slave = bank array plus downstream sink.
interface accu_outbuffer_drain_if #(
    parameter int nb_pe_row    = 8,
    parameter int buffer_width = 16,
    parameter int buffer_depth = 8192
);
    localparam int buffer_addr_width = $clog2(buffer_depth);

    logic [buffer_addr_width-1:0]        rAddr;
    logic                                rEn;
    logic [nb_pe_row*buffer_width-1:0]   buffer_out_all_rows;
    logic [nb_pe_row*buffer_width-1:0]   out_data;
    logic                                out_valid;
    logic                                out_ready;

    modport master (
        output rAddr, rEn, out_data, out_valid,
        input  buffer_out_all_rows, out_ready
    );

    modport slave (
        input  rAddr, rEn, out_data, out_valid,
        output buffer_out_all_rows, out_ready
    );
endinterface

// File: rtl/accu_outbuffer_drain.sv
// Sweeps a contiguous, wrapping address range of the accumulation output buffer
// and streams each row-parallel word out through a 2-entry skid FIFO.
//
// state | meaning
// IDLE  | waiting for start
// READ  | issuing bank reads under FIFO credit
// DRAIN | all reads issued, waiting for the last handshake
// DONE  | one-cycle completion, done=1
module accu_outbuffer_drain #(
    parameter int nb_pe_row    = 8,
    parameter int buffer_width = 16,
    parameter int buffer_depth = 8192,
    localparam int buffer_addr_width = $clog2(buffer_depth)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [buffer_addr_width-1:0] base_addr,
    input  logic [buffer_addr_width:0]   num_words,
    output logic                         busy,
    output logic                         done,
    accu_outbuffer_drain_if.master       bus
);
    localparam int aw = buffer_addr_width;
    localparam int dw = nb_pe_row * buffer_width;
    localparam logic [aw-1:0] last_addr = aw'(buffer_depth - 1);
    localparam logic [aw-1:0] one_a     = 1;
    localparam logic [aw:0]   one_w     = 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t          state;
    logic [aw-1:0]   addr;
    logic [aw:0]     remaining;
    logic [aw:0]     total;
    logic [aw:0]     hs_cnt;
    logic            inflight;
    logic [1:0]      fifo_cnt;
    logic [dw-1:0]   head;
    logic [dw-1:0]   tail;
    logic            pop;
    logic            push;
    logic            issue;
    logic [2:0]      outstanding;

    assign pop  = (fifo_cnt != 2'd0) && bus.out_ready;
    assign push = inflight;

    // Credit: words already buffered or on their way, minus the one leaving now.
    assign outstanding = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (state == READ) && (remaining != '0) && (outstanding < 3'd2);

    assign bus.rEn       = issue;
    assign bus.rAddr     = addr;
    assign bus.out_valid = (fifo_cnt != 2'd0);
    assign bus.out_data  = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            total     <= '0;
            hs_cnt    <= '0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= 1'b0;
            if (pop) hs_cnt <= hs_cnt + one_w;
            if (issue) begin
                addr      <= (addr == last_addr) ? '0 : addr + one_a;
                remaining <= remaining - one_w;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= num_words;
                        total     <= num_words;
                        hs_cnt    <= '0;
                        busy      <= 1'b1;
                        if (num_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue && remaining == one_w) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (hs_cnt + one_w) == total) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Skid FIFO: head is the registered output word, tail holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt <= 2'd0;
            head     <= '0;
            tail     <= '0;
        end else begin
            case (fifo_cnt)
                2'd0: begin
                    if (push) begin
                        head     <= bus.buffer_out_all_rows;
                        fifo_cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head <= bus.buffer_out_all_rows;
                    end else if (push) begin
                        tail     <= bus.buffer_out_all_rows;
                        fifo_cnt <= 2'd2;
                    end else if (pop) begin
                        fifo_cnt <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head <= tail;
                        if (push) tail <= bus.buffer_out_all_rows;
                        else      fifo_cnt <= 2'd1;
                    end
                end
            endcase
        end
    end

    no_fifo_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && fifo_cnt == 2'd2));

endmodule
